fir_mac_secuencial: RTL
=======================

// Module: fir_mac_secuencial
// PURPOSE
//  Sequential fixed-point FIR filter core. Holds a Taps-deep sample delay line and drives ONE shared
//  external saturating signed multiplier, one tap at a time: feeds it x[k]/c[k], consumes its product.
//  Accumulates the products with a saturating add and emits one filtered sample per accepted input.
//  Upstream: ADC/sample source. Downstream: output sample register / DAC path.
// PARAMETERS
//  Width      23  total signed fixed-point width (sign + magnitude + fraction)
//  Presicion  14  fraction bits; 1.0 = 2**Presicion = 16384
//  Taps        5  number of coefficients / delay-line depth (>=2)
// PORTS
//  clk           in   1              single clock, rising edge
//  rst_n         in   1              asynchronous, active-low reset
//  sample_in     in   Width          signed input sample
//  sample_valid  in   1              one-cycle strobe: sample_in is new
//  ready         out  1              1 = IDLE, next sample_valid accepted
//  coef_flat     in   Taps*Width     c[k] = coef_flat[k*Width +: Width], signed; stable while !ready
//  mul_a         out  Width          registered multiplier operand = x[k]
//  mul_b         out  Width          registered multiplier operand = c[k]
//  mul_y         in   Width          saturated product from the multiplier (combinational of mul_a/mul_b)
//  y_out         out  Width          filtered sample, held until next result
//  y_valid       out  1              one-cycle pulse: y_out updated
//  overrun       out  1              one-cycle pulse: sample_valid arrived while !ready (sample dropped)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, delay line x[0..Taps-1]=0, acc=0, k=0, mul_a=mul_b=0,
//   y_out=0, y_valid=0, overrun=0. ready=1 once reset is released.
//  FSM (ready = (state==IDLE)):
//   IDLE : sample_valid -> x[0]<=sample_in, x[i]<=x[i-1], acc<=0, k<=0, go LOAD. Else stay.
//   LOAD : mul_a<=x[k], mul_b<=c[k]; go ACC.
//   ACC  : acc<=sat_add(acc, mul_y); if k==Taps-1 go DONE else k<=k+1, go LOAD.
//   DONE : y_out<=acc, y_valid<=1 (cleared next edge); go IDLE.
//  Latency: accept edge E0; y_valid high from edge E(2*Taps+1) to E(2*Taps+2); Taps=5 -> 11 edges.
//   Throughput: one sample per 2*Taps+2 cycles; sample_valid in the IDLE cycle right after DONE accepted.
//  sat_add: Width-bit signed sum; same-sign operands with differing result sign -> clamp to
//   MAX = 2**(Width-1)-1 (positive overflow) or MIN = -(2**(Width-1)-1) (negative); symmetric range,
//   most-negative code never produced. Intermediate acc is clamped every tap (not only at the end).
//  sample_valid while !ready: sample ignored, delay line untouched, overrun pulses 1 cycle; computation
//   in progress unaffected.
//  sample_valid coincident with DONE: DONE takes priority, sample dropped, overrun pulses.
//  coef_flat changed while !ready: undefined result (host contract); no internal latching.
//  Reset asserted mid-operation: immediate abort to reset values; no y_valid for the aborted sample.
//  mul_a/mul_b only change in LOAD; mul_y sampled only in ACC (one full cycle of settling).
// STRUCTURE
//  Shared package/include: Width/Presicion defaults, MAX/MIN constants, FSM state encoding
//   (IDLE, LOAD, ACC, DONE; 2 bits), tap-index width $clog2(Taps).
//  One sub-module: sumador_saturado (combinational Width-bit saturating signed adder, reused elsewhere).
//  Delay line, FSM, tap counter, operand/result registers stay in this module; multiplier is external.
// TESTING  (bench connects a saturating fixed-point multiplier model to mul_a/mul_b/mul_y; Taps=5)
//  1 Reset: hold rst_n=0, toggle inputs -> y_out=0, y_valid=0, overrun=0, mul_a=mul_b=0; release -> ready=1.
//  2 Impulse: c={16384,8192,4096,0,0}; samples 16384,0,0,0,0 -> y_out=16384,8192,4096,0,0.
//  3 Latency: one sample accepted at E0 -> ready=0 E0..E(11), y_valid high exactly E11..E12, once.
//  4 Saturation: all c=16384, five samples 4194303 -> 5th y_out=4194303; five samples -4194303 -> -4194303.
//  5 Overrun: sample_valid 3 cycles after accept -> overrun 1-cycle pulse, y_out equals no-overrun result.
//  6 Reset mid-op: rst_n=0 during ACC of tap 2 -> no y_valid; after release next impulse sees cleared history.

Source files
------------

// File: rtl/fir_mac_secuencial_pkg.sv
// Shared constants and FSM encoding for the sequential MAC-based FIR core.
// Q-format: Width total bits, Presicion fraction bits (1.0 = 2**Presicion).
package fir_mac_secuencial_pkg;

  localparam int WIDTH     = 23;
  localparam int PRESICION = 14;
  localparam int TAPS      = 5;
  localparam int TAP_W     = $clog2(TAPS);

  // Symmetric saturation range: the most-negative code is never produced.
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fir_mac_secuencial_sumador.sv
// Combinational Width-bit signed adder clamping to the symmetric range
// [-(2**(Width-1)-1), 2**(Width-1)-1].
module sumador_saturado #(
  parameter int Width = 23
) (
  input  logic signed [Width-1:0] a,
  input  logic signed [Width-1:0] b,
  output logic signed [Width-1:0] y
);

  localparam logic signed [Width-1:0] MAX_V = {1'b0, {(Width-1){1'b1}}};
  localparam logic signed [Width-1:0] MIN_V = {1'b1, {(Width-2){1'b0}}, 1'b1};
  localparam logic signed [Width-1:0] NEG_V = {1'b1, {(Width-1){1'b0}}};

  logic signed [Width-1:0] sum;

  always_comb begin
    sum = a + b;
    y   = sum;
    if ((a[Width-1] == b[Width-1]) && (sum[Width-1] != a[Width-1])) begin
      y = a[Width-1] ? MIN_V : MAX_V;
    end else if (sum == NEG_V) begin
      // An exact most-negative sum is folded onto MIN to keep the range symmetric.
      y = MIN_V;
    end
  end

endmodule

// File: rtl/fir_mac_secuencial.sv
// Sequential FIR core: Taps-deep delay line, one shared external multiplier,
// saturating accumulate per tap, one output sample per accepted input.
module fir_mac_secuencial
  import fir_mac_secuencial_pkg::*;
#(
  parameter int Width = WIDTH,
  parameter int Taps  = TAPS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [Width-1:0]        sample_in,
  input  logic                    sample_valid,
  output logic                    ready,
  input  logic [Taps*Width-1:0]   coef_flat,
  output logic [Width-1:0]        mul_a,
  output logic [Width-1:0]        mul_b,
  input  logic [Width-1:0]        mul_y,
  output logic [Width-1:0]        y_out,
  output logic                    y_valid,
  output logic                    overrun,
  output logic [1:0]              dbg_state
);

  // Handshake: sample_valid is a one-cycle strobe taken only when ready
  // (state IDLE); a strobe while busy is dropped and flagged on overrun.
  localparam int KW = $clog2(Taps);

  state_e                  state_q, state_d;
  logic signed [Width-1:0] x_q [Taps];
  logic signed [Width-1:0] x_d [Taps];
  logic signed [Width-1:0] acc_q, acc_d;
  logic [KW-1:0]           k_q, k_d;
  logic [Width-1:0]        mul_a_q, mul_a_d;
  logic [Width-1:0]        mul_b_q, mul_b_d;
  logic [Width-1:0]        y_out_q, y_out_d;
  logic                    y_valid_q, y_valid_d;
  logic                    overrun_q, overrun_d;

  logic signed [Width-1:0] x_k;
  logic [Width-1:0]        coef_k;
  logic signed [Width-1:0] acc_sum;

  sumador_saturado #(.Width(Width)) u_sumador (
    .a (acc_q),
    .b (mul_y),
    .y (acc_sum)
  );

  always_comb begin
    x_k    = '0;
    coef_k = '0;
    for (int i = 0; i < Taps; i++) begin
      if (k_q == KW'(i)) begin
        x_k    = x_q[i];
        coef_k = coef_flat[i*Width +: Width];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    acc_d     = acc_q;
    k_d       = k_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;
    overrun_d = sample_valid && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          x_d[0] = sample_in;
          for (int i = 1; i < Taps; i++) x_d[i] = x_q[i-1];
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mul_a_d = x_k;
        mul_b_d = coef_k;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        // mul_y has had the whole LOAD->ACC cycle to settle from the new operands.
        acc_d = acc_sum;
        if (k_q == KW'(Taps-1)) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        y_out_d   = acc_q;
        y_valid_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < Taps; i++) x_q[i] <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign y_out     = y_out_q;
  assign y_valid   = y_valid_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule
